loop_iter_engine: RTL

Parametrised, synthesizable sequential engine that executes a bounded loop one iteration per cycle. The loop is a while, do-while or forever loop with an accumulate body (`acc += step`) and an unsigned `acc < limit` condition. It is the hardware reference target for lowering unbounded loop statements: the ingest flow maps while/do-while/forever bodies onto it with an explicit iteration cap and abort, and golden simulations compare against it.

---
 rtl/loop_iter_pkg.sv | 27 ++
 rtl/loop_cond_eval.sv | 40 ++++
 rtl/loop_iter_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/loop_iter_pkg.sv
// Shared types for the bounded loop engine: loop kind, FSM state and completion status.
package loop_iter_pkg;

  typedef enum logic [1:0] {
    WHILE    = 2'd0,
    DO_WHILE = 2'd1,
    FOREVER  = 2'd2
  } loop_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    OVERFLOW = 2'd1,
    ABORTED  = 2'd2,
    MATCHED  = 2'd3
  } status_e;

  function automatic loop_mode_e mode_from_param(input logic [1:0] m);
    return loop_mode_e'(m);
  endfunction

endpackage

// File: rtl/loop_cond_eval.sv
// Combinational exit / pattern-match evaluation for one loop iteration.
// Match terms are present only when LOOP_ITER_ENGINE_MATCH_EN is defined.
module loop_cond_eval
  import loop_iter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] limit_i,
  input  loop_mode_e       mode_i,
  input  logic             first_i,
`ifdef LOOP_ITER_ENGINE_MATCH_EN
  input  logic [WIDTH-1:0] match_val_i,
  input  logic [WIDTH-1:0] match_mask_i,
`endif
  output logic             exit_cond_o,
  output logic             match_hit_o
);

  logic below_limit;

  assign below_limit = (acc_i < limit_i);

  always_comb begin
    exit_cond_o = 1'b0;
    unique case (mode_i)
      WHILE:    exit_cond_o = !below_limit;
      // do-while always runs its body once before testing
      DO_WHILE: exit_cond_o = !first_i && !below_limit;
      default:  exit_cond_o = 1'b0;
    endcase
  end

`ifdef LOOP_ITER_ENGINE_MATCH_EN
  assign match_hit_o = !first_i && ((acc_i & match_mask_i) == (match_val_i & match_mask_i));
`else
  assign match_hit_o = 1'b0;
`endif

endmodule

// File: rtl/loop_iter_engine.sv
// Bounded while/do-while/forever accumulate loop, one body per cycle, with cap and abort.
// Optional pattern-match early exit enabled by LOOP_ITER_ENGINE_MATCH_EN.
module loop_iter_engine
  import loop_iter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 16,
  parameter int MODE     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [WIDTH-1:0]              init_val,
  input  logic [WIDTH-1:0]              step,
  input  logic [WIDTH-1:0]              limit,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  output logic [1:0]                    status
`ifdef LOOP_ITER_ENGINE_MATCH_EN
  ,
  input  logic [WIDTH-1:0]              match_val,
  input  logic [WIDTH-1:0]              match_mask
`endif
);

  localparam int         CW    = $clog2(MAX_ITER+1);
  localparam loop_mode_e LMODE = mode_from_param(MODE[1:0]);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] step_q, limit_q;
  logic             load;
  logic             exit_cond, match_hit;

`ifdef LOOP_ITER_ENGINE_MATCH_EN
  logic [WIDTH-1:0] match_val_q, match_mask_q;
`endif

  assign load = (state_q == IDLE) && start_valid;

  loop_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .acc_i        (acc_q),
    .limit_i      (limit_q),
    .mode_i       (LMODE),
    .first_i      (first_q),
`ifdef LOOP_ITER_ENGINE_MATCH_EN
    .match_val_i  (match_val_q),
    .match_mask_i (match_mask_q),
`endif
    .exit_cond_o  (exit_cond),
    .match_hit_o  (match_hit)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          acc_d    = init_val;
          cnt_d    = '0;
          first_d  = 1'b1;
          status_d = OK;
          state_d  = RUN;
        end
      end
      RUN: begin
        // exit priority: abort, match, loop condition, iteration cap
        if (abort) begin
          status_d = ABORTED;
          state_d  = DONE;
        end else if (match_hit) begin
          status_d = MATCHED;
          state_d  = DONE;
        end else if (exit_cond) begin
          status_d = OK;
          state_d  = DONE;
        end else if (cnt_q == CW'(MAX_ITER)) begin
          status_d = OVERFLOW;
          state_d  = DONE;
        end else begin
          acc_d   = acc_q + step_q;
          cnt_d   = cnt_q + CW'(1);
          first_d = 1'b0;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= OK;
      cnt_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (load) begin
      step_q  <= step;
      limit_q <= limit;
`ifdef LOOP_ITER_ENGINE_MATCH_EN
      match_val_q  <= match_val;
      match_mask_q <= match_mask;
`endif
    end
  end

  // result fields are only visible in DONE so reset and idle read as zero
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done_valid  = (state_q == DONE);
  assign result      = (state_q == DONE) ? acc_q    : '0;
  assign iter_count  = (state_q == DONE) ? cnt_q    : '0;
  assign status      = (state_q == DONE) ? status_q : 2'b00;

endmodule
